// File: rtl/power_gate_pkg.sv
// Shared types and constants for the power-gate sequencer: state encoding,
// per-state output decode and shared-timer sizing.
package power_gate_pkg;

    typedef enum logic [3:0] {
        StActive    = 4'd0,
        StGateClk   = 4'd1,
        StIsolate   = 4'd2,
        StSave      = 4'd3,
        StPwrDown   = 4'd4,
        StOff       = 4'd5,
        StPwrUp     = 4'd6,
        StRestore   = 4'd7,
        StDeisolate = 4'd8,
        StUngate    = 4'd9,
        StFault     = 4'd10
    } pg_state_e;

    typedef struct packed {
        logic clk_en;
        logic iso_en;
        logic pwr_en;
        logic ret_save;
        logic ret_restore;
    } pg_out_t;

    // Bit order: clk_en, iso_en, pwr_en, ret_save, ret_restore
    localparam pg_out_t OutActive    = 5'b10100;
    localparam pg_out_t OutGateClk   = 5'b00100;
    localparam pg_out_t OutIsolate   = 5'b01100;
    localparam pg_out_t OutSave      = 5'b01110;
    localparam pg_out_t OutPwrDown   = 5'b01000;
    localparam pg_out_t OutOff       = 5'b01000;
    localparam pg_out_t OutPwrUp     = 5'b01100;
    localparam pg_out_t OutRestore   = 5'b01101;
    localparam pg_out_t OutDeisolate = 5'b00100;
    localparam pg_out_t OutUngate    = 5'b10100;
    localparam pg_out_t OutFault     = 5'b01000;

    function automatic pg_out_t state_outputs(input pg_state_e state);
        case (state)
            StActive:    return OutActive;
            StGateClk:   return OutGateClk;
            StIsolate:   return OutIsolate;
            StSave:      return OutSave;
            StPwrDown:   return OutPwrDown;
            StOff:       return OutOff;
            StPwrUp:     return OutPwrUp;
            StRestore:   return OutRestore;
            StDeisolate: return OutDeisolate;
            StUngate:    return OutUngate;
            default:     return OutFault;
        endcase
    endfunction

    // The idle count is the only use that can exceed 8 bits.
    function automatic int unsigned timer_width(input int unsigned idle_cycles);
        return (idle_cycles > 255) ? 16 : 8;
    endfunction

endpackage

// File: rtl/power_gate_sequencer_timer.sv
// Loadable saturating down-counter with zero flag, shared by the idle,
// acknowledge-timeout and settle counts of the power-gate sequencer.
module pg_timer #(
    parameter int unsigned       Width    = 8,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= ResetVal;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/power_gate_sequencer.sv
// Moore sequencer for one power-gated domain: clock gate, isolate, save, switch off,
// and the reverse on wake, with idle auto-sleep, switch-ack timeout and sticky fault.
module power_gate_sequencer
    import power_gate_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned ACK_TIMEOUT   = 16,
    parameter int unsigned IDLE_CYCLES   = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic sleep_req,
    input  logic wake_req,
    input  logic activity,
    input  logic auto_sleep_en,
    input  logic pwr_ack,
    input  logic clear_fault,
    output logic clk_en,
    output logic iso_en,
    output logic ret_save,
    output logic ret_restore,
    output logic pwr_en,
    output logic busy,
    output logic asleep,
    output logic fault
);

    localparam int unsigned TimerWidth = timer_width(IDLE_CYCLES);
    localparam logic [TimerWidth-1:0] IdleLoad   = TimerWidth'(IDLE_CYCLES - 1);
    localparam logic [TimerWidth-1:0] AckLoad    = TimerWidth'(ACK_TIMEOUT - 1);
    localparam logic [TimerWidth-1:0] SettleLoad = TimerWidth'(SETTLE_CYCLES - 1);

    pg_state_e state_q, state_d;
    logic      settle_q, settle_d;   // PWR_UP phase: 0 = waiting for ack, 1 = settling
    logic      tmr_load, tmr_dec, tmr_zero;
    logic [TimerWidth-1:0] tmr_val;
    pg_out_t   outs;

    pg_timer #(
        .Width    (TimerWidth),
        .ResetVal (IdleLoad)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        tmr_load = 1'b0;
        tmr_val  = IdleLoad;
        tmr_dec  = 1'b0;

        case (state_q)
            StActive: begin
                // Timer at zero means IDLE_CYCLES-1 idle cycles already counted.
                if (!wake_req && (sleep_req || (auto_sleep_en && tmr_zero && !activity))) begin
                    state_d = StGateClk;
                end else if (activity) begin
                    tmr_load = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            StGateClk: state_d = StIsolate;
            StIsolate: state_d = StSave;
            StSave:    state_d = StPwrDown;
            StPwrDown: begin
                if (!pwr_ack) begin
                    state_d = StOff;
                end else if (tmr_zero) begin
                    state_d = StFault;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            StOff: begin
                if (wake_req) begin
                    state_d = StPwrUp;
                end
            end
            StPwrUp: begin
                if (!settle_q) begin
                    if (pwr_ack) begin
                        tmr_load = 1'b1;
                        tmr_val  = SettleLoad;
                        settle_d = 1'b1;
                    end else if (tmr_zero) begin
                        state_d = StFault;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end else begin
                    if (!pwr_ack) begin
                        tmr_load = 1'b1;
                        tmr_val  = AckLoad;
                        settle_d = 1'b0;
                    end else if (tmr_zero) begin
                        state_d = StRestore;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
            end
            StRestore:   state_d = StDeisolate;
            StDeisolate: state_d = StUngate;
            StUngate:    state_d = StActive;
            StFault: begin
                if (clear_fault) begin
                    state_d = StOff;
                end
            end
            default: state_d = StFault;
        endcase

        if (state_d != state_q) begin
            tmr_load = 1'b1;
            settle_d = 1'b0;
            case (state_d)
                StActive:           tmr_val = IdleLoad;
                StPwrDown, StPwrUp: tmr_val = AckLoad;
                default:            tmr_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StActive;
            settle_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    always_comb begin
        outs        = state_outputs(state_q);
        clk_en      = outs.clk_en;
        iso_en      = outs.iso_en;
        pwr_en      = outs.pwr_en;
        ret_save    = outs.ret_save;
        ret_restore = outs.ret_restore;
        busy        = !(state_q inside {StActive, StOff, StFault});
        asleep      = (state_q == StOff);
        fault       = (state_q == StFault);
    end

endmodule

// File: tb/tb_power_gate_sequencer.sv
// Directed bench for power_gate_sequencer: behavioural model with per-cycle compare,
// plus hand-computed cycle-exact checks of the sequencing timeline.
module tb_power_gate_sequencer;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned ACK_TO = 16;
    localparam int unsigned IDLE   = 32;

    logic clk = 1'b0;
    logic rst, sleep_req, wake_req, activity, auto_sleep_en, pwr_ack, clear_fault;
    logic clk_en, iso_en, ret_save, ret_restore, pwr_en, busy, asleep, fault;

    always #5 clk = ~clk;

    power_gate_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .ACK_TIMEOUT   (ACK_TO),
        .IDLE_CYCLES   (IDLE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sleep_req     (sleep_req),
        .wake_req      (wake_req),
        .activity      (activity),
        .auto_sleep_en (auto_sleep_en),
        .pwr_ack       (pwr_ack),
        .clear_fault   (clear_fault),
        .clk_en        (clk_en),
        .iso_en        (iso_en),
        .ret_save      (ret_save),
        .ret_restore   (ret_restore),
        .pwr_en        (pwr_en),
        .busy          (busy),
        .asleep        (asleep),
        .fault         (fault)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Power-switch stand-in: 0 = follow pwr_en after ack_delay cycles, 1 = stuck on, 2 = stuck off
    int ack_mode = 1;
    int ack_delay = 3;
    logic [7:0] hist = '1;
    initial begin
        pwr_ack = 1'b1;
        forever begin
            @(posedge clk);
            hist = {hist[6:0], pwr_en};
            @(negedge clk);
            case (ack_mode)
                1:       pwr_ack = 1'b1;
                2:       pwr_ack = 1'b0;
                default: pwr_ack = hist[ack_delay-1];
            endcase
        end
    end

    // Behavioural model: which step the domain is in, plus up-counting cycle tallies.
    typedef enum int {
        MActive, MGate, MIso, MSave, MDown, MOff, MUp, MRestore, MDeiso, MUngate, MFault
    } mode_t;
    mode_t m = MActive;
    int idle_n = 0;
    int wait_n = 0;
    int ack_run = 0;
    bit model_valid = 1'b0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m = MActive; idle_n = 0; wait_n = 0; ack_run = 0;
            model_valid = 1'b1;
        end else begin
            case (m)
                MActive: begin
                    if (!wake_req && (sleep_req ||
                        (auto_sleep_en && !activity && idle_n == IDLE - 1))) m = MGate;
                    else if (activity) idle_n = 0;
                    else if (idle_n < IDLE - 1) idle_n++;
                end
                MGate: m = MIso;
                MIso:  m = MSave;
                MSave: begin m = MDown; wait_n = 0; end
                MDown: begin
                    if (!pwr_ack) m = MOff;
                    else begin
                        wait_n++;
                        if (wait_n == ACK_TO) m = MFault;
                    end
                end
                MOff: if (wake_req) begin m = MUp; wait_n = 0; ack_run = 0; end
                MUp: begin
                    if (pwr_ack) begin
                        ack_run++;
                        if (ack_run == SETTLE + 1) m = MRestore;
                    end else if (ack_run > 0) begin
                        ack_run = 0; wait_n = 0;
                    end else begin
                        wait_n++;
                        if (wait_n == ACK_TO) m = MFault;
                    end
                end
                MRestore: m = MDeiso;
                MDeiso:   m = MUngate;
                MUngate:  begin m = MActive; idle_n = 0; end
                MFault:   if (clear_fault) m = MOff;
                default:  m = MFault;
            endcase
        end
    end

    // {clk_en, iso_en, pwr_en, ret_save, ret_restore, busy, asleep, fault}
    function automatic logic [7:0] model_outputs(input mode_t md);
        logic c, i, p, s, r, b, a, f;
        c = (md inside {MActive, MUngate});
        i = (md inside {MIso, MSave, MDown, MOff, MUp, MRestore, MFault});
        p = !(md inside {MDown, MOff, MFault});
        s = (md == MSave);
        r = (md == MRestore);
        b = !(md inside {MActive, MOff, MFault});
        a = (md == MOff);
        f = (md == MFault);
        return {c, i, p, s, r, b, a, f};
    endfunction

    initial forever begin
        @(negedge clk);
        if (model_valid) begin
            logic [7:0] act, exp;
            act = {clk_en, iso_en, pwr_en, ret_save, ret_restore, busy, asleep, fault};
            exp = model_outputs(m);
            n_cmp++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL cycle_model t=%0t mode=%s got=%b expected=%b",
                         $time, m.name(), act, exp);
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_asleep(input string name);
        int i = 0;
        while (asleep !== 1'b1 && i < 100) begin tick(); i++; end
        check(name, asleep, 1'b1);
    endtask

    task automatic wait_active(input string name);
        int i = 0;
        while (!(clk_en === 1'b1 && busy === 1'b0) && i < 100) begin tick(); i++; end
        check(name, busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clk_en"}, clk_en, 1'b1);
        check({tag, "_pwr_en"}, pwr_en, 1'b1);
        check({tag, "_iso_en"}, iso_en, 1'b0);
        check({tag, "_ret_save"}, ret_save, 1'b0);
        check({tag, "_ret_restore"}, ret_restore, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_asleep"}, asleep, 1'b0);
        check({tag, "_fault"}, fault, 1'b0);
    endtask

    initial begin
        rst = 1'b1; sleep_req = 1'b0; wake_req = 1'b0; activity = 1'b0;
        auto_sleep_en = 1'b0; clear_fault = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(4);
        ack_mode = 0; ack_delay = 3;

        // Down sequence, ack follows pwr_en after 3 cycles
        sleep_req = 1'b1;
        tick();
        sleep_req = 1'b0;
        check("down_clk_en_n1", clk_en, 1'b0);
        check("down_iso_n1", iso_en, 1'b0);
        tick(); check("down_iso_n2", iso_en, 1'b1);
        tick(); check("down_ret_save_n3", ret_save, 1'b1);
        tick(); check("down_pwr_en_n4", pwr_en, 1'b0);
        check("down_ret_save_n4", ret_save, 1'b0);
        tick(3); check("down_asleep_n7", asleep, 1'b0);
        tick(); check("down_asleep_n8", asleep, 1'b1);

        // Up sequence, ack 2 cycles after pwr_en
        ack_delay = 2;
        wake_req = 1'b1;
        tick();
        wake_req = 1'b0;
        check("up_pwr_en_m1", pwr_en, 1'b1);
        check("up_busy_m1", busy, 1'b1);
        tick(6); check("up_ret_restore_m7", ret_restore, 1'b0);
        tick(); check("up_ret_restore_m8", ret_restore, 1'b1);
        tick(); check("up_iso_m9", iso_en, 1'b0);
        check("up_ret_restore_m9", ret_restore, 1'b0);
        tick(); check("up_clk_en_m10", clk_en, 1'b1);
        tick(); check("up_busy_m11", busy, 1'b0);

        // Auto-sleep after exactly IDLE idle cycles
        activity = 1'b1; auto_sleep_en = 1'b1;
        tick();
        activity = 1'b0;
        tick(IDLE - 1); check("auto_idle_31", clk_en, 1'b1);
        tick(); check("auto_idle_32", clk_en, 1'b0);
        wait_asleep("auto_reach_off");
        activity = 1'b1;
        wake_req = 1'b1; tick(); wake_req = 1'b0;
        wait_active("auto_rewake");

        // Activity pulse on the 21st sampled cycle delays auto-sleep by 21
        tick();
        for (int i = 1; i <= 53; i++) begin
            activity = (i == 21);
            tick();
            if (i == 52) check("auto_pulse_52", clk_en, 1'b1);
            if (i == 53) check("auto_pulse_53", clk_en, 1'b0);
        end
        activity = 1'b0; auto_sleep_en = 1'b0;

        // Power-down ack timeout
        ack_mode = 1;
        tick(3); check("down_to_pwr_en", pwr_en, 1'b0);
        tick(ACK_TO - 1); check("down_to_not_yet", fault, 1'b0);
        tick(); check("down_to_fault", fault, 1'b1);
        check("down_to_pwr_en_f", pwr_en, 1'b0);
        check("down_to_iso_f", iso_en, 1'b1);
        clear_fault = 1'b1; tick(); clear_fault = 1'b0;
        check("clear_asleep", asleep, 1'b1);
        check("clear_fault_low", fault, 1'b0);

        // Power-up ack timeout
        ack_mode = 2;
        wake_req = 1'b1; tick(); wake_req = 1'b0;
        check("up_to_busy", busy, 1'b1);
        tick(ACK_TO - 1); check("up_to_not_yet", fault, 1'b0);
        tick(); check("up_to_fault", fault, 1'b1);
        clear_fault = 1'b1; tick(); clear_fault = 1'b0;

        // Ack drop during settle restarts the wait
        wake_req = 1'b1; tick(); wake_req = 1'b0;
        ack_mode = 1; tick(2);
        ack_mode = 2; tick();
        ack_mode = 1; tick(4);
        check("settle_restart_m7", ret_restore, 1'b0);
        tick(); check("settle_restart_m8", ret_restore, 1'b1);
        activity = 1'b1;
        wait_active("settle_restart_active");

        // Conflicting requests
        ack_mode = 0; ack_delay = 2;
        sleep_req = 1'b1; wake_req = 1'b1;
        tick(4);
        check("both_active_busy", busy, 1'b0);
        check("both_active_clk_en", clk_en, 1'b1);
        wake_req = 1'b0; tick(); sleep_req = 1'b0;
        wait_asleep("both_reach_off");
        sleep_req = 1'b1; wake_req = 1'b1; tick();
        sleep_req = 1'b0; wake_req = 1'b0;
        check("both_off_busy", busy, 1'b1);
        check("both_off_pwr_en", pwr_en, 1'b1);
        wait_active("both_off_active");

        // Reset mid-sequence: in SAVE, then in PWR_UP
        sleep_req = 1'b1; tick(); sleep_req = 1'b0;
        tick(2); check("pre_rst_save", ret_save, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        check_reset_outputs("rst_save");
        sleep_req = 1'b1; tick(); sleep_req = 1'b0;
        wait_asleep("rst_up_reach_off");
        wake_req = 1'b1; tick(); wake_req = 1'b0;
        check("pre_rst_pwr_up", busy, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        check_reset_outputs("rst_pwr_up");
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
